// File: rtl/alu_exec_stage.sv
// alu_exec_stage: operand-supply and writeback stage wrapped around an 8-bit ALU.
// Holds an 8-entry register file and drives the ALU operand and code registers.
// It captures the ALU result and flags, then writes the result back to a register.
// A start/busy/done handshake sequences one instruction at a time (IDLE->OPERAND->EXEC->WB).
// Optional feature macro ALU_CMP_EN: adds input Cmp; a compare op updates the flags only.
module alu_exec_stage #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned REG_CNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_CMP_EN
    input  logic              Cmp,
`endif
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [2:0]        Rd,
    input  logic [2:0]        Rs1,
    input  logic [2:0]        Rs2,
    input  logic              Ld_En,
    input  logic [2:0]        Ld_Addr,
    input  logic [DATA_W-1:0] Ld_Data,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [2:0]        ALU_Code,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              Carry,
    input  logic              isZero,
    output logic              Busy,
    output logic              Done,
    output logic              Flag_C,
    output logic              Flag_Z,
    input  logic [2:0]        Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data
);

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPERAND = 2'd1,
        S_EXEC    = 2'd2,
        S_WB      = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [REG_CNT];

    // Instruction fields latched when Start is accepted
    logic [CODE_W-1:0]   op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   rs1_q;
    logic [ADDR_W-1:0]   rs2_q;

    // Result latch captured at the end of EXEC
    logic [DATA_W-1:0]   res_q;
    logic                carry_q;
    logic                zero_q;

    // Whether the WB edge writes the destination register
    logic                wb_write_c;

`ifdef ALU_CMP_EN
    logic                cmp_q;
    assign wb_write_c = ~cmp_q;
`else
    assign wb_write_c = 1'b1;
`endif

    // Busy follows the state register directly
    assign Busy = (state != S_IDLE);

    // Debug read port is combinational so it shows a write the cycle after it lands
    assign Dbg_Data = regs[Dbg_Addr];

    // Sequencer, register file, operand/result latches and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs[i] <= '0;
            end
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_Code <= '0;
            Flag_C   <= 1'b0;
            Flag_Z   <= 1'b0;
            Done     <= 1'b0;
`ifdef ALU_CMP_EN
            cmp_q    <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A load and a Start on the same edge: the load lands first,
                    // so the following OPERAND read sees it
                    if (Ld_En) begin
                        regs[Ld_Addr] <= Ld_Data;
                    end
                    if (Start) begin
                        op_q  <= Op;
                        rd_q  <= Rd;
                        rs1_q <= Rs1;
                        rs2_q <= Rs2;
`ifdef ALU_CMP_EN
                        cmp_q <= Cmp;
`endif
                        state <= S_OPERAND;
                    end
                end
                S_OPERAND: begin
                    // Operands are read here, before any WB write of this op
                    ALU_A    <= regs[rs1_q];
                    ALU_B    <= regs[rs2_q];
                    ALU_Code <= op_q;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    res_q   <= ALU_Out;
                    carry_q <= Carry;
                    zero_q  <= isZero;
                    state   <= S_WB;
                end
                S_WB: begin
                    if (wb_write_c) begin
                        regs[rd_q] <= res_q;
                    end
                    Flag_C <= carry_q;
                    Flag_Z <= zero_q;
                    Done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a stub ALU, a reference model and a scoreboard.
// Build with +define+ALU_CMP_EN to exercise the compare feature.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Start;
    logic [2:0] Op, Rd, Rs1, Rs2;
    logic       Ld_En;
    logic [2:0] Ld_Addr;
    logic [7:0] Ld_Data;
    logic [7:0] ALU_A, ALU_B;
    logic [2:0] ALU_Code;
    logic [7:0] ALU_Out;
    logic       Carry, isZero;
    logic       Busy, Done, Flag_C, Flag_Z;
    logic [2:0] Dbg_Addr;
    logic [7:0] Dbg_Data;
`ifdef ALU_CMP_EN
    logic       Cmp;
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_CMP_EN
        .Cmp(Cmp),
`endif
        .Start(Start), .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
        .Ld_En(Ld_En), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Code(ALU_Code),
        .ALU_Out(ALU_Out), .Carry(Carry), .isZero(isZero),
        .Busy(Busy), .Done(Done), .Flag_C(Flag_C), .Flag_Z(Flag_Z),
        .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
    );

    always #5 clk = ~clk;

    // Stub ALU
    logic [8:0] alu_wide;
    always_comb begin
        case (ALU_Code)
            3'd0:    alu_wide = {1'b0, ALU_A} + {1'b0, ALU_B};
            3'd1:    alu_wide = {1'b0, ALU_A} - {1'b0, ALU_B};
            3'd2:    alu_wide = {1'b0, ALU_A & ALU_B};
            3'd3:    alu_wide = {1'b0, ALU_A | ALU_B};
            3'd4:    alu_wide = {1'b0, ALU_A ^ ALU_B};
            3'd5:    alu_wide = {1'b0, ~ALU_A};
            3'd6:    alu_wide = {ALU_A, 1'b0};
            default: alu_wide = {1'b0, ALU_B};
        endcase
    end
    assign ALU_Out = alu_wide[7:0];
    assign Carry   = alu_wide[8];
    assign isZero  = (alu_wide[7:0] == 8'h00);

    // Debug port shared between the stimulus and the monitor
    logic       mon_own = 1'b0;
    logic [2:0] mon_addr = 3'd0;
    logic [2:0] stim_addr = 3'd0;
    assign Dbg_Addr = mon_own ? mon_addr : stim_addr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int op; int rd; int a; int b; int res; int c; int z; int rdval; int issue;
    } exp_t;

    exp_t expq[$];
    int   mregs[8];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   exp_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic
    task automatic model_alu(input int op, input int a, input int b, output int r, output int c);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin s = a * 2; r = s % 256; c = (s > 255) ? 1 : 0; end
            default: r = b;
        endcase
    endtask

    // Scoreboard monitor: every Done must match the oldest outstanding op
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (Done === 1'b1) begin
                done_cnt++;
                if (expq.size() == 0) begin
                    chk("spurious_done", 32'(Done), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("latency", 32'(cyc), 32'(e.issue + 4));
                    chk("alu_a", 32'(ALU_A), 32'(e.a));
                    chk("alu_b", 32'(ALU_B), 32'(e.b));
                    chk("alu_code", 32'(ALU_Code), 32'(e.op));
                    chk("flag_c", 32'(Flag_C), 32'(e.c));
                    chk("flag_z", 32'(Flag_Z), 32'(e.z));
                    mon_addr = 3'(e.rd);
                    mon_own  = 1'b1;
                    #1;
                    chk("rd_value", 32'(Dbg_Data), 32'(e.rdval));
                    mon_own  = 1'b0;
                end
            end
        end
    end

    // Issue one op from an idle negedge; returns at the negedge after the accepting edge
    task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                         input int cmp, input int lde, input int la, input int ld);
        exp_t e;
        int r, c;
        Op = 3'(op); Rd = 3'(rd); Rs1 = 3'(rs1); Rs2 = 3'(rs2);
        Ld_En = 1'(lde); Ld_Addr = 3'(la); Ld_Data = 8'(ld);
`ifdef ALU_CMP_EN
        Cmp = 1'(cmp);
`endif
        Start = 1'b1;
        if (lde != 0) mregs[la] = ld;
        e.op = op; e.rd = rd; e.a = mregs[rs1]; e.b = mregs[rs2];
        model_alu(op, e.a, e.b, r, c);
        e.res = r; e.c = c; e.z = (r == 0) ? 1 : 0;
        if (!(CMP_EN && cmp != 0)) mregs[rd] = r;
        e.rdval = mregs[rd];
        e.issue = cyc;
        expq.push_back(e);
        exp_done++;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; Ld_En = 1'b0;
    endtask

    task automatic idle_load(input int la, input int ld);
        Ld_En = 1'b1; Ld_Addr = 3'(la); Ld_Data = 8'(ld);
        mregs[la] = ld;
        @(posedge clk);
        @(negedge clk);
        Ld_En = 1'b0;
    endtask

    task automatic wait_idle(input bit no_done);
        int n = 0;
        while ((Busy || (no_done && Done)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'(Busy | Done), 32'd0);
    endtask

    task automatic dbg_chk(input string name, input int addr);
        stim_addr = 3'(addr);
        #1;
        chk(name, 32'(Dbg_Data), 32'(mregs[addr]));
    endtask

    initial begin
        int d0, n, r;
        rst_n = 1'b0; Start = 1'b0; Op = '0; Rd = '0; Rs1 = '0; Rs2 = '0;
        Ld_En = 1'b0; Ld_Addr = '0; Ld_Data = '0;
`ifdef ALU_CMP_EN
        Cmp = 1'b0;
`endif
        foreach (mregs[i]) mregs[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_flag_c", 32'(Flag_C), 32'd0);
        chk("rst_flag_z", 32'(Flag_Z), 32'd0);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        chk("rst_alu_code", 32'(ALU_Code), 32'd0);
        for (int i = 0; i < 8; i++) dbg_chk("rst_reg", i);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with a same-edge load of r2
        idle_load(1, 8'h03);
        issue(0, 3, 1, 2, 0, 1, 2, 8'h01);
        @(negedge clk);
        chk("operand_a_n1", 32'(ALU_A), 32'h03);
        chk("operand_b_n1", 32'(ALU_B), 32'h01);
        chk("busy_inflight", 32'(Busy), 32'd1);
        wait_idle(1);
        dbg_chk("add_r3", 3);

        // Carry and zero, destination equals a source
        idle_load(1, 8'hFF);
        issue(0, 1, 1, 2, 0, 0, 0, 0);
        @(negedge clk);
        chk("carry_op_a", 32'(ALU_A), 32'hFF);
        wait_idle(1);
        dbg_chk("carry_r1", 1);

        // Start and Ld_En during EXEC are ignored
        d0 = done_cnt;
        issue(0, 5, 3, 3, 0, 0, 0, 0);
        @(negedge clk);
        Start = 1'b1; Ld_En = 1'b1; Ld_Addr = 3'd2; Ld_Data = 8'hAA;
        @(negedge clk);
        Start = 1'b0; Ld_En = 1'b0;
        wait_idle(1);
        repeat (6) @(negedge clk);
        chk("busy_reject_dones", 32'(done_cnt - d0), 32'd1);
        dbg_chk("busy_reject_r2", 2);

        // Reset during EXEC aborts the op
        d0 = done_cnt;
        issue(0, 6, 3, 3, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        expq.delete();
        exp_done--;
        foreach (mregs[i]) mregs[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(Busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        dbg_chk("abort_r6", 6);

`ifdef ALU_CMP_EN
        // Compare: flags only, destination untouched
        d0 = done_cnt;
        idle_load(7, 8'h5A);
        idle_load(1, 8'h05);
        issue(1, 7, 1, 2, 1, 1, 2, 8'h05);
        wait_idle(1);
        repeat (2) @(negedge clk);
        chk("cmp_flag_z", 32'(Flag_Z), 32'd1);
        chk("cmp_dones", 32'(done_cnt - d0), 32'd1);
        dbg_chk("cmp_r7", 7);
`endif

        // Randomised traffic with back-to-back issue and busy-time noise
        for (int it = 0; it < 200; it++) begin
            wait_idle(0);
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                if ($urandom_range(0, 1) == 1)
                    idle_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
                else begin
                    @(posedge clk);
                    @(negedge clk);
                end
            end else begin
                issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
                n = 0;
                while (Busy && n < 10) begin
                    Start = 1'($urandom); Ld_En = 1'($urandom);
                    Ld_Addr = 3'($urandom); Ld_Data = 8'($urandom);
                    Op = 3'($urandom); Rd = 3'($urandom);
                    Rs1 = 3'($urandom); Rs2 = 3'($urandom);
                    @(negedge clk);
                    n++;
                end
                if (n >= 10) chk("busy_stuck", 32'(Busy), 32'd0);
                Start = 1'b0; Ld_En = 1'b0;
            end
        end

        wait_idle(1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("done_total", 32'(done_cnt), 32'(exp_done));
        for (int i = 0; i < 8; i++) dbg_chk("final_reg", i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
